i2c_reg_controller: RTL and testbench
=====================================

Name: i2c_reg_controller

Overview:
- Sequences the I2C `master` block to perform complete single-byte register transactions (write or read) from one command.
- Sits between a host/register-file command interface and the `master` control/data ports.
- Issues START, address, register index, data and STOP, plus repeated START for reads, and reports ack/error status.

Parameters:
- ADDR_WIDTH, 8, width of the register index byte(s). Only 8 is supported; any other value is a compile-time error.
- TIMEOUT_CYCLES, 65535, clk_in cycles allowed per master byte before abort (used only with the optional feature).

Ports:
- clk_in  input  1  system clock, same clock as `master`
- reset_n  input  1  asynchronous active-low reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  controller idle and able to accept a command
- cmd_read  input  1  1 = register read, 0 = register write
- cmd_dev_addr  input  7  7-bit target device address
- cmd_reg_addr  input  8  target register index
- cmd_wdata  input  8  write data (ignored for reads)
- rsp_valid  output  1  one-cycle pulse: transaction finished
- rsp_rdata  output  8  read data; 0 for writes
- rsp_nack  output  1  some byte was not acknowledged by the target
- rsp_err  output  1  start_err, arbitration_err or timeout occurred
- mode  output  1  to master: 0 transmit, 1 receive
- transfer_start  output  1  to master: begin a START / repeated START
- transfer_continue  output  1  to master: continue with the next byte, no STOP
- data_tx  output  8  to master: byte to send
- transfer_ready  input  1  from master: bus idle, ready for START
- interrupt  input  1  from master: byte finished; ack/data_rx valid
- transaction_complete  input  1  from master: STOP issued, bus released
- ack  input  1  from master: 1 = ACK received for the last byte
- start_err, arbitration_err  input  1 each  from master: error flags
- data_rx  input  8  from master: received byte

Behaviour:
- Reset values (asynchronous, while reset_n = 0): state IDLE; cmd_ready 1; rsp_valid 0; rsp_rdata 0; rsp_nack 0; rsp_err 0; mode 0; transfer_start 0; transfer_continue 0; data_tx 0.
- Command handshake:
  - A command is accepted on the clk_in edge where cmd_valid & cmd_ready.
  - All cmd_* fields are latched on that edge; cmd_ready drops on the same edge.
  - cmd_ready returns to 1 in the cycle after the rsp_valid pulse.
- State machine: IDLE -> WAIT_READY -> ADDR_W -> REG -> (WDATA | ADDR_R -> RDATA) -> STOP -> RESP -> IDLE.
- WAIT_READY:
  - Hold until transfer_ready = 1.
  - Then assert transfer_start = 1, mode = 0, data_tx = {dev_addr, 1'b0}, and move to ADDR_W.
- Byte-completion rule, applied in every byte state:
  - The controller waits for interrupt.
  - On the interrupt cycle it samples ack and data_rx, then drives the next byte's data_tx, mode, transfer_start and transfer_continue.
  - The master samples these on the following edge; they are held until the next interrupt.
- ADDR_W, on interrupt:
  - ack = 0 -> set rsp_nack; drop transfer_continue and transfer_start to request STOP; go to STOP.
  - ack = 1 -> data_tx = reg_addr, transfer_continue = 1; go to REG.
- REG, on interrupt:
  - ack = 0 -> handled as for ADDR_W.
  - write command -> data_tx = wdata, continue = 1; go to WDATA.
  - read command -> transfer_start = 1, continue = 1 (repeated START), data_tx = {dev_addr, 1'b1}; go to ADDR_R.
- WDATA, on interrupt:
  - Record ~ack into rsp_nack.
  - Drop continue/start; go to STOP.
- ADDR_R, on interrupt:
  - ack = 0 -> NACK abort as for ADDR_W.
  - ack = 1 -> mode = 1, continue = 0 so the master NACKs the single read byte; go to RDATA.
- RDATA, on interrupt:
  - rsp_rdata <= data_rx.
  - Go to STOP.
- STOP:
  - Wait for transaction_complete, then go to RESP.
- RESP:
  - rsp_valid = 1 for exactly one cycle.
  - rsp_* hold their values until the next command is accepted, then clear.
- Errors:
  - start_err or arbitration_err seen in any non-IDLE state -> set rsp_err and go directly to RESP. No STOP wait: the master has already lost or released the bus.
  - rsp_err has priority over rsp_nack; both may be 1.
- Simultaneous events:
  - interrupt coincident with an error flag -> error path wins.
  - cmd_valid while busy is ignored.
- Reset mid-transaction:
  - All master control outputs drop immediately.
  - No response is generated.
- Latency:
  - Accept -> first transfer_start is 1 cycle if transfer_ready is already high.
  - RESP pulse is 1 cycle after transaction_complete.

Optional Feature:
- I2C_REG_CTRL_TIMEOUT_EN defined:
  - A 16-bit watchdog counter reloads on every state change and counts in all non-IDLE states.
  - Reaching TIMEOUT_CYCLES sets rsp_err, drops transfer_start/transfer_continue and goes to RESP.
- Not defined:
  - No counter is built.
  - The controller waits indefinitely on the master.

Test Plan:
- Write dev 0x50, reg 0x10, data 0xA5, master model acks all -> data_tx sequence 0xA0, 0x10, 0xA5; continue 1,1,0; one rsp_valid with rsp_nack 0, rsp_err 0, rsp_rdata 0x00.
- Read dev 0x50, reg 0x3C, model returns 0x5A -> data_tx 0xA0, 0x3C, then transfer_start with 0xA1; mode = 1 for the last byte; rsp_rdata 0x5A, rsp_nack 0.
- Address NACK on write to dev 0x21 (ack = 0 after 0x42) -> no further bytes sent, STOP requested, rsp_nack 1, rsp_err 0.
- arbitration_err pulsed during REG -> rsp_valid within 2 cycles with rsp_err 1; cmd_ready returns 1 on the next cycle.
- reset_n pulsed low during WDATA -> all outputs at reset values asynchronously; a new write then completes normally.
- With I2C_REG_CTRL_TIMEOUT_EN and TIMEOUT_CYCLES = 100, model never raises interrupt after START -> rsp_err 1 with rsp_valid at cycle 101 after the START.

Source files
------------

// File: rtl/i2c_reg_controller.sv
// Sequences an I2C byte master through complete single-byte register write/read transactions.
// Optional per-byte watchdog is built when I2C_REG_CTRL_TIMEOUT_EN is defined.
module i2c_reg_controller #(
    parameter int ADDR_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                  clk_in,
    input  logic                  reset_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_read,
    input  logic [6:0]            cmd_dev_addr,
    input  logic [ADDR_WIDTH-1:0] cmd_reg_addr,
    input  logic [7:0]            cmd_wdata,
    output logic                  rsp_valid,
    output logic [7:0]            rsp_rdata,
    output logic                  rsp_nack,
    output logic                  rsp_err,
    output logic                  mode,
    output logic                  transfer_start,
    output logic                  transfer_continue,
    output logic [7:0]            data_tx,
    input  logic                  transfer_ready,
    input  logic                  interrupt,
    input  logic                  transaction_complete,
    input  logic                  ack,
    input  logic                  start_err,
    input  logic                  arbitration_err,
    input  logic [7:0]            data_rx
);

    if (ADDR_WIDTH != 8) begin : g_bad_addr_width
        $error("i2c_reg_controller: only ADDR_WIDTH = 8 is supported");
    end
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("i2c_reg_controller: TIMEOUT_CYCLES must fit the 16-bit watchdog");
    end

    typedef enum logic [3:0] {
        IDLE, WAIT_READY, ADDR_W, REG, WDATA, ADDR_R, RDATA, STOP, RESP
    } state_t;

    state_t state, state_d;

    logic                  rd_q;
    logic [6:0]            dev_q;
    logic [ADDR_WIDTH-1:0] reg_q;
    logic [7:0]            wdata_q;

    logic       mode_d, start_d, cont_d, nack_d, err_d;
    logic [7:0] data_tx_d, rdata_d;
    logic       timeout, abort;

`ifdef I2C_REG_CTRL_TIMEOUT_EN
    logic [15:0] wd_cnt;

    // Reloads on every state change so the budget applies to each master byte separately.
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n)                              wd_cnt <= '0;
        else if (state_d != state || state == IDLE) wd_cnt <= '0;
        else                                       wd_cnt <= wd_cnt + 16'd1;
    end

    assign timeout = (state != IDLE) && (wd_cnt == 16'(TIMEOUT_CYCLES));
`else
    assign timeout = 1'b0;
`endif

    // The master has already lost or released the bus, so errors skip the STOP wait.
    assign abort     = (state != IDLE) && (state != RESP) &&
                       (start_err || arbitration_err || timeout);
    assign cmd_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);

    // NOTE: command fields are pure data loaded before every use, so they carry no reset.
    always_ff @(posedge clk_in) begin
        if (state == IDLE && cmd_valid) begin
            rd_q    <= cmd_read;
            dev_q   <= cmd_dev_addr;
            reg_q   <= cmd_reg_addr;
            wdata_q <= cmd_wdata;
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            state             <= IDLE;
            mode              <= 1'b0;
            transfer_start    <= 1'b0;
            transfer_continue <= 1'b0;
            data_tx           <= '0;
            rsp_rdata         <= '0;
            rsp_nack          <= 1'b0;
            rsp_err           <= 1'b0;
        end else begin
            state             <= state_d;
            mode              <= mode_d;
            transfer_start    <= start_d;
            transfer_continue <= cont_d;
            data_tx           <= data_tx_d;
            rsp_rdata         <= rdata_d;
            rsp_nack          <= nack_d;
            rsp_err           <= err_d;
        end
    end

    always_comb begin
        state_d = state;
        if (abort) begin
            state_d = RESP;
        end else begin
            unique case (state)
                IDLE:       if (cmd_valid)            state_d = WAIT_READY;
                WAIT_READY: if (transfer_ready)       state_d = ADDR_W;
                ADDR_W:     if (interrupt)            state_d = ack ? REG : STOP;
                REG:        if (interrupt)            state_d = !ack ? STOP : (rd_q ? ADDR_R : WDATA);
                WDATA:      if (interrupt)            state_d = STOP;
                ADDR_R:     if (interrupt)            state_d = ack ? RDATA : STOP;
                RDATA:      if (interrupt)            state_d = STOP;
                STOP:       if (transaction_complete) state_d = RESP;
                RESP:                                 state_d = IDLE;
                default:                              state_d = IDLE;
            endcase
        end
    end

    // NOTE: every *_d holds its register value by default, so no latch is inferred.
    always_comb begin
        mode_d    = mode;
        start_d   = transfer_start;
        cont_d    = transfer_continue;
        data_tx_d = data_tx;
        rdata_d   = rsp_rdata;
        nack_d    = rsp_nack;
        err_d     = rsp_err;
        if (abort) begin
            err_d   = 1'b1;
            start_d = 1'b0;
            cont_d  = 1'b0;
            mode_d  = 1'b0;
        end else if (state == IDLE) begin
            if (cmd_valid) begin
                rdata_d = '0;
                nack_d  = 1'b0;
                err_d   = 1'b0;
            end
        end else if (state == WAIT_READY) begin
            if (transfer_ready) begin
                start_d   = 1'b1;
                cont_d    = 1'b0;
                mode_d    = 1'b0;
                data_tx_d = {dev_q, 1'b0};
            end
        end else if (interrupt && state inside {ADDR_W, REG, WDATA, ADDR_R, RDATA}) begin
            start_d = 1'b0;
            cont_d  = 1'b0;
            mode_d  = 1'b0;
            if (!ack && state inside {ADDR_W, REG, ADDR_R}) begin
                nack_d = 1'b1;
            end else begin
                unique case (state)
                    ADDR_W: begin
                        data_tx_d = reg_q;
                        cont_d    = 1'b1;
                    end
                    REG: begin
                        cont_d    = 1'b1;
                        start_d   = rd_q;
                        data_tx_d = rd_q ? {dev_q, 1'b1} : wdata_q;
                    end
                    WDATA:   nack_d  = ~ack;
                    ADDR_R:  mode_d  = 1'b1;
                    RDATA:   rdata_d = data_rx;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_reg_controller.sv
// Directed bench for i2c_reg_controller: the bench plays the byte master by hand.
// The watchdog scenario runs only when I2C_REG_CTRL_TIMEOUT_EN is defined.
module tb_i2c_reg_controller;

    logic       clk_in, reset_n;
    logic       cmd_valid, cmd_ready, cmd_read;
    logic [6:0] cmd_dev_addr;
    logic [7:0] cmd_reg_addr, cmd_wdata;
    logic       rsp_valid, rsp_nack, rsp_err;
    logic [7:0] rsp_rdata;
    logic       mode, transfer_start, transfer_continue;
    logic [7:0] data_tx, data_rx;
    logic       transfer_ready, interrupt, transaction_complete, ack;
    logic       start_err, arbitration_err;

    int n_pass  = 0;
    int n_total = 0;
    int lat     = 0;
    int seen    = 0;

    i2c_reg_controller #(.ADDR_WIDTH(8), .TIMEOUT_CYCLES(100)) dut (
        .clk_in               (clk_in),
        .reset_n              (reset_n),
        .cmd_valid            (cmd_valid),
        .cmd_ready            (cmd_ready),
        .cmd_read             (cmd_read),
        .cmd_dev_addr         (cmd_dev_addr),
        .cmd_reg_addr         (cmd_reg_addr),
        .cmd_wdata            (cmd_wdata),
        .rsp_valid            (rsp_valid),
        .rsp_rdata            (rsp_rdata),
        .rsp_nack             (rsp_nack),
        .rsp_err              (rsp_err),
        .mode                 (mode),
        .transfer_start       (transfer_start),
        .transfer_continue    (transfer_continue),
        .data_tx              (data_tx),
        .transfer_ready       (transfer_ready),
        .interrupt            (interrupt),
        .transaction_complete (transaction_complete),
        .ack                  (ack),
        .start_err            (start_err),
        .arbitration_err      (arbitration_err),
        .data_rx              (data_rx)
    );

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: observed hang expected finish");
        $fatal(1, "bench did not finish");
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    // Fields are scrambled after the accept edge so only latched values can reach the bus.
    task automatic send_cmd(input logic rd, input logic [6:0] dev, input logic [7:0] ra,
                            input logic [7:0] wd);
        cmd_valid = 1'b1; cmd_read = rd; cmd_dev_addr = dev; cmd_reg_addr = ra; cmd_wdata = wd;
        tick();
        cmd_valid = 1'b0; cmd_read = ~rd; cmd_dev_addr = ~dev; cmd_reg_addr = ~ra; cmd_wdata = ~wd;
    endtask

    task automatic master_byte(input logic a, input logic [7:0] rx);
        interrupt = 1'b1; ack = a; data_rx = rx;
        tick();
        interrupt = 1'b0; ack = 1'b0; data_rx = 8'h00;
    endtask

    task automatic finish_stop();
        transaction_complete = 1'b1;
        tick();
        transaction_complete = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; cmd_valid = 1'b0; cmd_read = 1'b0; cmd_dev_addr = '0;
        cmd_reg_addr = '0; cmd_wdata = '0; transfer_ready = 1'b1; interrupt = 1'b0;
        transaction_complete = 1'b0; ack = 1'b0; start_err = 1'b0; arbitration_err = 1'b0;
        data_rx = '0;
        tick(); tick();
        check("reset_ctrl", {cmd_ready, rsp_valid, rsp_nack, rsp_err, mode, transfer_start,
                             transfer_continue}, 7'b1000000);
        check("reset_data", {data_tx, rsp_rdata}, 16'h0000);
        reset_n = 1'b1;
        tick();

        // Register write, all bytes acknowledged.
        send_cmd(1'b0, 7'h50, 8'h10, 8'hA5);
        check("wr_busy", cmd_ready, 1'b0);
        tick();
        check("wr_start", {transfer_start, transfer_continue, mode, data_tx}, {3'b100, 8'hA0});
        master_byte(1'b1, 8'h00);
        check("wr_reg", {transfer_start, transfer_continue, mode, data_tx}, {3'b010, 8'h10});
        master_byte(1'b1, 8'h00);
        check("wr_data", {transfer_start, transfer_continue, mode, data_tx}, {3'b010, 8'hA5});
        master_byte(1'b1, 8'h00);
        check("wr_stopreq", {transfer_start, transfer_continue}, 2'b00);
        tick();
        check("wr_wait_stop", rsp_valid, 1'b0);
        finish_stop();
        check("wr_rsp", {rsp_valid, rsp_nack, rsp_err, rsp_rdata, cmd_ready}, {3'b100, 8'h00, 1'b0});
        tick();
        check("wr_idle", {rsp_valid, cmd_ready}, 2'b01);

        // Register read with transfer_ready initially low.
        transfer_ready = 1'b0;
        send_cmd(1'b1, 7'h50, 8'h3C, 8'hFF);
        tick(); tick();
        check("rd_hold_ready", transfer_start, 1'b0);
        transfer_ready = 1'b1;
        tick();
        check("rd_start", {transfer_start, transfer_continue, mode, data_tx}, {3'b100, 8'hA0});
        master_byte(1'b1, 8'h00);
        check("rd_reg", {transfer_start, transfer_continue, mode, data_tx}, {3'b010, 8'h3C});
        master_byte(1'b1, 8'h00);
        check("rd_restart", {transfer_start, transfer_continue, mode, data_tx}, {3'b110, 8'hA1});
        master_byte(1'b1, 8'h00);
        check("rd_rx_mode", {transfer_start, transfer_continue, mode}, 3'b001);
        master_byte(1'b0, 8'h5A);
        check("rd_stopreq", {transfer_start, transfer_continue}, 2'b00);
        finish_stop();
        check("rd_rsp", {rsp_valid, rsp_nack, rsp_err, rsp_rdata}, {3'b100, 8'h5A});
        tick();

        // Address NACK on a write.
        send_cmd(1'b0, 7'h21, 8'h05, 8'h66);
        check("nk_rdata_clr", rsp_rdata, 8'h00);
        tick();
        check("nk_start", {transfer_start, transfer_continue, mode, data_tx}, {3'b100, 8'h42});
        master_byte(1'b0, 8'h00);
        check("nk_abort", {transfer_start, transfer_continue, mode, data_tx}, {3'b000, 8'h42});
        tick();
        check("nk_no_more", {transfer_start, transfer_continue, data_tx}, {2'b00, 8'h42});
        finish_stop();
        check("nk_rsp", {rsp_valid, rsp_nack, rsp_err}, 3'b110);
        tick();
        check("nk_hold", {rsp_valid, rsp_nack, rsp_err, cmd_ready}, 4'b0101);

        // Arbitration loss in REG, coincident with an interrupt.
        send_cmd(1'b0, 7'h50, 8'h20, 8'h99);
        check("ar_nack_clr", rsp_nack, 1'b0);
        tick();
        master_byte(1'b1, 8'h00);
        check("ar_reg", data_tx, 8'h20);
        interrupt = 1'b1; ack = 1'b1; arbitration_err = 1'b1;
        tick();
        interrupt = 1'b0; ack = 1'b0; arbitration_err = 1'b0;
        check("ar_rsp", {rsp_valid, rsp_err, rsp_nack, transfer_start, transfer_continue}, 5'b11000);
        check("ar_err_wins", data_tx, 8'h20);
        tick();
        check("ar_ready_back", {cmd_ready, rsp_valid, rsp_err}, 3'b101);

        // Asynchronous reset during WDATA, then a clean write.
        send_cmd(1'b0, 7'h50, 8'h11, 8'h3C);
        tick();
        master_byte(1'b1, 8'h00);
        master_byte(1'b1, 8'h00);
        check("rs_wdata", {transfer_start, transfer_continue, data_tx}, {2'b01, 8'h3C});
        #2 reset_n = 1'b0;
        #1;
        check("rs_async_ctrl", {cmd_ready, rsp_valid, rsp_nack, rsp_err, mode, transfer_start,
                                transfer_continue}, 7'b1000000);
        check("rs_async_data", {data_tx, rsp_rdata}, 16'h0000);
        tick();
        reset_n = 1'b1;
        tick();
        check("rs_no_rsp", {rsp_valid, cmd_ready}, 2'b01);
        send_cmd(1'b0, 7'h50, 8'h10, 8'h7E);
        tick();
        check("rs_start", {transfer_start, data_tx}, {1'b1, 8'hA0});
        master_byte(1'b1, 8'h00);
        master_byte(1'b1, 8'h00);
        check("rs_data", {transfer_continue, data_tx}, {1'b1, 8'h7E});
        master_byte(1'b1, 8'h00);
        finish_stop();
        check("rs_rsp", {rsp_valid, rsp_nack, rsp_err, rsp_rdata}, {3'b100, 8'h00});
        tick();

        // Data byte NACK is reported without an error.
        send_cmd(1'b0, 7'h50, 8'h12, 8'h01);
        tick();
        master_byte(1'b1, 8'h00);
        master_byte(1'b1, 8'h00);
        master_byte(1'b0, 8'h00);
        finish_stop();
        check("dn_rsp", {rsp_valid, rsp_nack, rsp_err}, 3'b110);
        tick();

`ifdef I2C_REG_CTRL_TIMEOUT_EN
        // Master never finishes the address byte.
        send_cmd(1'b0, 7'h50, 8'h10, 8'hA5);
        tick();
        check("to_start", transfer_start, 1'b1);
        for (int k = 1; k <= 200; k++) begin
            tick();
            if (rsp_valid === 1'b1) begin
                lat = k;
                break;
            end
        end
        check("to_latency", 16'(lat), 16'd101);
        check("to_rsp", {rsp_err, transfer_start, transfer_continue}, 3'b100);
        tick();
        check("to_idle", cmd_ready, 1'b1);
`else
        // Without the watchdog the controller keeps waiting on the master.
        send_cmd(1'b0, 7'h50, 8'h10, 8'hA5);
        tick();
        for (int k = 0; k < 150; k++) begin
            tick();
            if (rsp_valid === 1'b1) seen++;
        end
        check("nw_no_rsp", 16'(seen), 16'd0);
        check("nw_still_start", {transfer_start, cmd_ready}, 2'b10);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
